// File: rtl/vga_stream_controller_if.sv
// Pixel-stream handshake bundle for vga_stream_controller.
// Ports: in_valid/in_ready handshake, in_data {r,g,b}, in_sof first-pixel flag.
interface vga_stream_controller_if #(
   parameter int COLOR_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3*COLOR_W-1:0] in_data;
   logic                 in_sof;

   modport master (
      output in_valid, in_data, in_sof,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, in_sof,
      output in_ready
   );
endinterface

// File: rtl/vga_stream_controller.sv
// VGA timing generator fed by a buffered pixel stream with frame alignment.
// Ports: clk, rst (async high), s_in stream slave, clr_err;
//        hsync/vsync/de/red/green/blue/frame_start (registered),
//        underflow/sync_err (sticky), fifo_level (occupancy).
module vga_stream_controller #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int CLK_DIV    = 2,
   parameter int COLOR_W    = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int SYNC_POL   = 0,
   parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   vga_stream_controller_if.slave        s_in,
   input  logic                          clr_err,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          de,
   output logic [COLOR_W-1:0]            red,
   output logic [COLOR_W-1:0]            green,
   output logic [COLOR_W-1:0]            blue,
   output logic                          frame_start,
   output logic                          underflow,
   output logic                          sync_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = 3 * COLOR_W;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [AW:0]     DEPTH    = (AW + 1)'(FIFO_DEPTH);
   localparam logic            P_ON     = 1'(SYNC_POL);

   typedef enum logic [1:0] {S_WAIT, S_RUN, S_HUNT} state_t;

   logic [DIVW-1:0] r_div;
   logic [HW-1:0]   r_h;
   logic [VW-1:0]   r_v;
   logic [DW:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [AW:0]     r_level;
   state_t          r_state;
   logic            r_hs, r_vs, r_de, r_fs, r_uf, r_se;
   logic [DW-1:0]   r_rgb;

   logic            w_pix_en, w_pix_end, w_active, w_origin;
   logic            w_ready, w_push, w_empty, w_head_sof;
   logic [DW-1:0]   w_head_rgb;
   logic            w_pop, w_show, w_fs, w_uf_set, w_se_set;
   state_t          w_nxt;

   // A pixel period starts on pix_en and ends on pix_end; decisions are
   // taken at the start so colour stays aligned with de for the whole period.
   assign w_pix_en  = (r_div == '0);
   assign w_pix_end = (r_div == DIV_LAST);
   assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
   assign w_origin  = (r_h == '0) && (r_v == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
      end else begin
         r_div <= w_pix_end ? '0 : r_div + 1'b1;
         if (w_pix_end) begin
            if (r_h == H_LAST) begin
               r_h <= '0;
               r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
               r_h <= r_h + 1'b1;
            end
         end
      end
   end

   assign w_ready        = (r_level < DEPTH);
   assign s_in.in_ready  = w_ready;
   assign w_push         = s_in.in_valid & w_ready;
   assign w_empty        = (r_level == '0);
   assign w_head_sof     = r_mem[r_rd][DW];
   assign w_head_rgb     = r_mem[r_rd][DW-1:0];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {s_in.in_sof, s_in.in_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_comb begin
      w_nxt    = r_state;
      w_pop    = 1'b0;
      w_show   = 1'b0;
      w_fs     = 1'b0;
      w_uf_set = 1'b0;
      w_se_set = 1'b0;
      unique case (r_state)
         S_WAIT: begin
            if (w_pix_en && w_origin && !w_empty) begin
               if (w_head_sof) begin
                  w_pop  = 1'b1;
                  w_show = 1'b1;
                  w_fs   = 1'b1;
                  w_nxt  = S_RUN;
               end else begin
                  w_nxt  = S_HUNT;
               end
            end
         end
         S_RUN: begin
            if (w_pix_en && w_active) begin
               if (w_empty) begin
                  w_uf_set = 1'b1;
                  w_nxt    = S_HUNT;
               end else if (w_head_sof && !w_origin) begin
                  // early sof is kept for the next frame origin
                  w_se_set = 1'b1;
                  w_nxt    = S_WAIT;
               end else if (!w_head_sof && w_origin) begin
                  w_se_set = 1'b1;
                  w_nxt    = S_HUNT;
               end else begin
                  w_pop  = 1'b1;
                  w_show = 1'b1;
                  w_fs   = w_origin;
               end
            end
         end
         S_HUNT: begin
            // drain stale pixels at clk rate until a frame start is at the head
            if (!w_empty) begin
               if (w_head_sof) w_nxt = S_WAIT;
               else            w_pop = 1'b1;
            end
         end
         default: w_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_WAIT;
         r_hs    <= ~P_ON;
         r_vs    <= ~P_ON;
         r_de    <= 1'b0;
         r_rgb   <= BG_COLOR;
         r_fs    <= 1'b0;
         r_uf    <= 1'b0;
         r_se    <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_hs    <= (r_h >= HS_BEG && r_h <= HS_END) ? P_ON : ~P_ON;
         r_vs    <= (r_v >= VS_BEG && r_v <= VS_END) ? P_ON : ~P_ON;
         r_de    <= w_active;
         if (!w_active)    r_rgb <= BG_COLOR;
         else if (w_pix_en) r_rgb <= w_show ? w_head_rgb : BG_COLOR;
         r_fs    <= w_fs;
         r_uf    <= w_uf_set | (r_uf & ~clr_err);
         r_se    <= w_se_set | (r_se & ~clr_err);
      end
   end

   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign de          = r_de;
   assign red         = r_rgb[DW-1 -: COLOR_W];
   assign green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
   assign blue        = r_rgb[COLOR_W-1:0];
   assign frame_start = r_fs;
   assign underflow   = r_uf;
   assign sync_err    = r_se;
   assign fifo_level  = r_level;

endmodule

// File: tb/tb_vga_stream_controller.sv
// Directed bench for vga_stream_controller on a reduced 16x8 raster.
// Ports: drives clk/rst/clr_err and the stream interface, checks all outputs.
module tb_vga_stream_controller;

   localparam logic [11:0] BG = 12'h5A3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_err = 1'b0;
   logic        hsync, vsync, de, frame_start, underflow, sync_err;
   logic [3:0]  red, green, blue;
   logic [4:0]  fifo_level;

   vga_stream_controller_if #(.COLOR_W(4)) s_if ();

   vga_stream_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(2), .COLOR_W(4), .FIFO_DEPTH(16),
      .SYNC_POL(0), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .s_in(s_if), .clr_err(clr_err),
      .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue),
      .frame_start(frame_start), .underflow(underflow),
      .sync_err(sync_err), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          k = 0;
   bit          post_rst = 1'b0;
   logic [12:0] src_q[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_de", de, 0);
      chk("rst_hs", hsync, 1);
      chk("rst_vs", vsync, 1);
      chk("rst_col", {red, green, blue}, BG);
      chk("rst_fs", frame_start, 0);
      chk("rst_uf", underflow, 0);
      chk("rst_se", sync_err, 0);
      chk("rst_lvl", fifo_level, 0);
      chk("rst_rdy", s_if.in_ready, 1);
   endtask

   // Raster model: after edge k the outputs describe pixel (k-1)/2.
   task automatic check_now();
      int p, h, v, f, idx;
      logic ede, ehs, evs, efs, euf, ese;
      logic [11:0] ec;
      p   = (k - 1) / 2;
      h   = p % 16;
      v   = (p / 16) % 8;
      f   = p / 128;
      idx = v * 8 + h;
      ede = (h < 8) && (v < 4);
      ehs = !(h >= 10 && h <= 12);
      evs = !(v >= 5 && v <= 6);
      ec  = BG;
      if (ede && !post_rst) begin
         case (f)
            1: ec = 12'(idx);
            2: ec = (idx < 12) ? 12'(32 + idx) : BG;
            3: ec = (idx < 10) ? 12'(200 + idx) : BG;
            4: ec = 12'(210 + idx);
            default: ec = BG;
         endcase
      end
      efs = !post_rst && (k == 257 || k == 513 || k == 769 || k == 1025);
      euf = !post_rst && ((k >= 553 && k < 600) || k >= 1281);
      ese = !post_rst && (k >= 805 && k < 900);
      chk("de", de, ede);
      chk("hsync", hsync, ehs);
      chk("vsync", vsync, evs);
      chk("colour", {red, green, blue}, ec);
      chk("frame_start", frame_start, efs);
      chk("underflow", underflow, euf);
      chk("sync_err", sync_err, ese);
   endtask

   task automatic step();
      logic acc;
      if (src_q.size() > 0) begin
         s_if.in_valid = 1'b1;
         {s_if.in_sof, s_if.in_data} = src_q[0];
      end else begin
         s_if.in_valid = 1'b0;
         s_if.in_sof   = 1'b0;
         s_if.in_data  = '0;
      end
      acc = s_if.in_valid && s_if.in_ready;
      clr_err = !post_rst && (k + 1 == 553 || k + 1 == 600 || k + 1 == 900);
      @(posedge clk);
      k++;
      if (acc) void'(src_q.pop_front());
      @(negedge clk);
      check_now();
   endtask

   initial begin
      s_if.in_valid = 1'b0;
      s_if.in_sof   = 1'b0;
      s_if.in_data  = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      k   = 0;

      while (k < 1340) begin
         if (k == 230)
            for (int i = 0; i < 44; i++)
               src_q.push_back({(i == 0 || i == 32), 12'(i)});
         if (k == 620)
            for (int i = 0; i < 42; i++)
               src_q.push_back({(i == 0 || i == 10), 12'(200 + i)});
         if (k == 1300)
            for (int i = 0; i < 20; i++)
               src_q.push_back({(i == 0), 12'(300 + i)});
         step();
         if (k == 250 || k == 256 || k == 1339) begin
            chk("full_lvl", fifo_level, 16);
            chk("full_rdy", s_if.in_ready, 0);
            chk("full_vld", s_if.in_valid, 1);
         end
      end

      #2 rst = 1'b1;
      #1 chk_reset_vals();
      src_q.delete();
      s_if.in_valid = 1'b0;
      @(negedge clk);
      chk_reset_vals();
      rst      = 1'b0;
      post_rst = 1'b1;
      k        = 0;
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
